alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 64-bit ALU.
- Adds a valid/ready handshake on both sides, status flags, shift and logic ops, and an iterative multi-cycle unsigned multiply.
- Sits between the operand-fetch stage and writeback.
- Single-cycle ops complete in 1 cycle. MUL takes WIDTH cycles. The block holds its result until the consumer takes it.

Parameters:
- WIDTH, 64, operand/result width in bits (≥4, power of 2).
- OPW, 4, opcode width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B/op are presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  OPW  opcode.
- out_valid  output  1  out/flags hold a result.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- carry  output  1  ADD carry-out / SUB borrow.
- ovf  output  1  MUL upper product half nonzero.
- bad_op  output  1  unsupported opcode was issued.

Behaviour:
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 EQ: out = 1 if A==B, else 0.
  - 5 XOR.
  - 6 SLL: A << B[log2(WIDTH)−1:0].
  - 7 SRL: logical A >> B[log2(WIDTH)−1:0].
  - 8 MUL: low WIDTH bits of unsigned A*B.
  - 9–15: out=0, bad_op=1.
- Arithmetic wraps mod 2^WIDTH.
- carry:
  - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: 1 iff A<B unsigned.
  - All other ops: 0.
- ovf: 1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero (MUL only); 0 for all other ops.
- zero is registered with out, never computed combinationally from out.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accept on in_valid && in_ready at a rising edge.
    - Non-MUL op: result and flags registered on that same edge; go to DONE.
    - MUL: latch A, B; clear the 2·WIDTH accumulator; load the iteration counter with WIDTH; go to MUL.
  - MUL: in_ready=0. Each cycle, add the shifted multiplicand if the current multiplier bit is 1, shift, and decrement the counter.
    - When the counter reaches 0, register out/ovf/zero (carry=0) and go to DONE.
    - Total: accept edge N, out_valid high after edge N+WIDTH.
  - DONE: out_valid=1, in_ready=0.
    - out, flags and bad_op are held stable until out_ready=1 at a rising edge, then go to IDLE.
    - No accept in the same cycle as the out_ready edge, so back-to-back throughput is one op per 2 cycles.
- in_ready and out_valid are decoded from state only; they have no combinational path from in_valid or out_ready.
- Operand inputs are ignored when in_ready=0. Changing A/B/op during MUL has no effect.
- Reset (async, any state, including mid-MUL):
  - State goes to IDLE.
  - out=0, zero=0, carry=0, ovf=0, bad_op=0, out_valid=0, counter=0, accumulator=0.
  - in_ready=1 while reset is high and after release.
  - A MUL in progress is discarded, and no result is emitted.
- out_ready while out_valid=0 has no effect.
- in_valid held high in DONE is not accepted until the cycle after returning to IDLE.

Test Plan:
- Reset, then ADD A=1, B=4 -> one cycle after accept: out_valid=1, out=5, carry=0, zero=0.
- ADD A=2, B=all-ones (−1) -> out=1, carry=1. Then SUB A=2, B=3 -> out=all-ones, carry=1. Then SUB A=3, B=3 -> out=0, zero=1.
- EQ A=2, B=2 -> out=1. EQ A=2, B=3 -> out=0, zero=1. Op 12 -> out=0, bad_op=1.
- MUL A=7, B=6 -> in_ready=0 for 64 cycles, out_valid after edge N+64, out=42, ovf=0. MUL A=2^63, B=2 -> out=0, ovf=1, zero=1.
- Backpressure: out_ready=0 for 5 cycles after SLL A=1, B=68 (shift amount 4) -> out=16 stable, out_valid=1, in_ready=0 throughout. out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Assert reset for 1 cycle at cycle 20 of a MUL -> all outputs 0, in_ready=1, no out_valid. A following ADD 1+1 -> out=2.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative
// shift-and-add unsigned multiplier that takes WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             bad_op
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_EQ  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL = OPW'(8);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               badop_q, badop_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry;
    logic               aluBad;
    logic [2*WIDTH-1:0] accSum;

    // Single-cycle result; MUL is handled by the iterative datapath instead.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        aluRes   = '0;
        aluCarry = 1'b0;
        aluBad   = 1'b0;
        case (op)
            OP_ADD: begin
                aluRes   = sum[WIDTH-1:0];
                aluCarry = sum[WIDTH];
            end
            OP_SUB: begin
                aluRes   = A - B;
                aluCarry = (A < B);
            end
            OP_AND: aluRes = A & B;
            OP_OR:  aluRes = A | B;
            OP_EQ:  aluRes = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_XOR: aluRes = A ^ B;
            OP_SLL: aluRes = A << B[SHW-1:0];
            OP_SRL: aluRes = A >> B[SHW-1:0];
            OP_MUL: aluRes = '0;
            default: aluBad = 1'b1;
        endcase
    end

    assign accSum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        badop_d  = badop_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = CNTW'(WIDTH);
                        state_d  = MUL;
                    end else begin
                        out_d   = aluRes;
                        zero_d  = (aluRes == '0);
                        carry_d = aluCarry;
                        ovf_d   = 1'b0;
                        badop_d = aluBad;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = accSum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNTW'(1);
                // Last iteration: the product is complete in accSum.
                if (cnt_q == CNTW'(1)) begin
                    out_d   = accSum[WIDTH-1:0];
                    zero_d  = (accSum[WIDTH-1:0] == '0);
                    carry_d = 1'b0;
                    ovf_d   = |accSum[2*WIDTH-1:WIDTH];
                    badop_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            badop_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            badop_q  <= badop_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign bad_op    = badop_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: expected results are queued at issue time
// and popped when the block presents a result.
module tb_alu_pipe;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          bad_op;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         bad;
        logic         isMul;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acceptCyc = 0;

    alu_pipe #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .carry(carry), .ovf(ovf), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] o);
        exp_t         e;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        e = '0;
        case (o)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.c = s[W]; end
            4'd1: begin e.res = a - b; e.c = (a < b); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = (a == b) ? 64'd1 : 64'd0;
            4'd5: e.res = a ^ b;
            4'd6: e.res = a << b[5:0];
            4'd7: e.res = a >> b[5:0];
            4'd8: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.v = |p[2*W-1:W];
                e.isMul = 1'b1;
            end
            default: e.bad = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        op = o;
        expQ.push_back(model(a, b, o));
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        op = 4'($urandom_range(0, 15));
    endtask

    task automatic checkOutput(input string tag, input int holdCycles);
        exp_t e;
        int   n = 0;
        logic busyOk = 1'b1;
        logic holdOk = 1'b1;
        logic [W-1:0] firstOut;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (in_ready !== 1'b0) busyOk = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid_seen"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_in_ready_low_while_busy"}, {63'd0, busyOk}, 64'd1);
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, "_latency"}, 64'(cyc - acceptCyc), e.isMul ? 64'(W) : 64'd0);
            check({tag, "_out"}, out, e.res);
            check({tag, "_flags"}, {60'd0, zero, carry, ovf, bad_op}, {60'd0, e.z, e.c, e.v, e.bad});
        end
        firstOut = out;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            if (out !== firstOut || out_valid !== 1'b1 || in_ready !== 1'b0) holdOk = 1'b0;
        end
        check({tag, "_held_under_backpressure"}, {63'd0, holdOk}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic sawValid;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        op = '0;
        repeat (3) @(negedge clk);
        check("reset_out", out, 64'd0);
        check("reset_handshake", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        check("reset_flags", {60'd0, zero, carry, ovf, bad_op}, 64'd0);
        reset = 1'b0;

        applyStimulus(64'd1, 64'd4, 4'd0);
        checkOutput("add_1_4", 0);
        applyStimulus(64'd2, {W{1'b1}}, 4'd0);
        checkOutput("add_carry", 0);
        applyStimulus(64'd2, 64'd3, 4'd1);
        checkOutput("sub_borrow", 0);
        applyStimulus(64'd3, 64'd3, 4'd1);
        checkOutput("sub_zero", 0);
        applyStimulus(64'd2, 64'd2, 4'd4);
        checkOutput("eq_true", 0);
        applyStimulus(64'd2, 64'd3, 4'd4);
        checkOutput("eq_false", 0);
        applyStimulus(64'hF0F0_1234_0000_FFFF, 64'h0FF0_4321_FFFF_00FF, 4'd2);
        checkOutput("and", 0);
        applyStimulus(64'hF0F0_1234_0000_FFFF, 64'h0FF0_4321_FFFF_00FF, 4'd3);
        checkOutput("or", 0);
        applyStimulus(64'hF0F0_1234_0000_FFFF, 64'h0FF0_4321_FFFF_00FF, 4'd5);
        checkOutput("xor", 0);
        applyStimulus(64'h8000_0000_0000_0001, 64'd65, 4'd7);
        checkOutput("srl", 0);
        applyStimulus(64'd5, 64'd9, 4'd12);
        checkOutput("bad_op12", 0);
        applyStimulus(64'd7, 64'd6, 4'd8);
        checkOutput("mul_7_6", 0);
        applyStimulus(64'h8000_0000_0000_0000, 64'd2, 4'd8);
        checkOutput("mul_ovf", 0);
        applyStimulus(64'hDEAD_BEEF_1234_5678, 64'h0000_0001_FFFF_0003, 4'd8);
        checkOutput("mul_big", 0);
        applyStimulus(64'd1, 64'd68, 4'd6);
        checkOutput("sll_backpressure", 5);

        applyStimulus(64'd123, 64'd456, 4'd8);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midmul_reset_out", out, 64'd0);
        check("midmul_reset_flags", {60'd0, zero, carry, ovf, bad_op}, 64'd0);
        check("midmul_reset_handshake", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        void'(expQ.pop_back());
        @(negedge clk);
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) sawValid = 1'b1;
        end
        check("no_result_after_reset", {63'd0, sawValid}, 64'd0);
        applyStimulus(64'd1, 64'd1, 4'd0);
        checkOutput("add_after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
